led_chaser_div: RTL and testbench
=================================

// Module: led_chaser_div
// PURPOSE
//  Parametrised LED pattern generator with an integrated programmable rate divider.
//  Generalises the fixed 8-LED shift pipe: LED width, divider width and pattern mode are configurable.
//  It also adds a runtime divisor load.
//  The divider produces a clock-enable strobe, not a derived clock, so the whole block runs on one clock.
//  Sits between a board-level top (switches/buttons) and the LED pins.
// PARAMETERS
//  LED_W     8    number of LEDs driven (>= 2)
//  DIV_W     8    divisor register / counter width
//  DIV_INIT  4    divisor value loaded at reset; step period = DIV_INIT+1 clocks
// PORTS
//  clock     in   1      system clock, all logic on rising edge
//  reset_n   in   1      synchronous reset, active low
//  enable    in   1      1 = run divider and pattern; 0 = freeze counter and pattern
//  div_load  in   1      1-cycle pulse: capture div_value into divisor register
//  div_value in   DIV_W  new divisor; step period = div_value+1 clocks
//  mode      in   2      00 rotate-left, 01 rotate-right, 10 bounce, 11 fill/drain
//  diode     out  LED_W  registered LED pattern
//  tick      out  1      registered strobe, high for exactly 1 cycle per pattern step
// BEHAVIOUR
//  Interface:
//  - One clock ('clock').
//  - Reset is synchronous and active-low ('reset_n'), sampled on the rising edge of clock.
//  Reset values:
//  - diode = 1, i.e. only bit0 set.
//  - cnt = 0; div_reg = DIV_INIT; tick = 0.
//  - Bounce direction = left; fill_bit = 1; mode_q = 00.
//  Divider:
//  - cnt counts up while enable=1.
//  - When cnt == div_reg and enable=1: cnt <= 0, and a step occurs at that edge.
//  - div_reg = 0 gives a step every clock.
//  Step at an edge:
//  - diode takes its next value.
//  - tick is high for the following cycle.
//  - Latency from the wrap edge to the diode change is 0 cycles; tick and the new diode value appear together.
//  div_load (any enable level):
//  - div_reg <= div_value and cnt <= 0.
//  - No step occurs in that cycle, even if cnt == div_reg. Load has priority over step.
//  enable = 0:
//  - cnt, diode, direction and fill_bit all hold; tick = 0.
//  - div_load still works.
//  Mode is sampled only at a step.
//  - If mode != mode_q, the step loads the mode's seed instead of advancing, and mode_q <= mode.
//  - Seeds: 00 -> 1. 01 -> 1<<(LED_W-1). 10 -> 1 with dir=left. 11 -> 0 with fill_bit=1.
//  Mode 00, rotate left: diode <= {diode[LED_W-2:0], diode[LED_W-1]}. For LED_W=8, 80 wraps to 01.
//  Mode 01, rotate right: diode <= {diode[0], diode[LED_W-1:1]}. For LED_W=8, 01 wraps to 80.
//  Mode 10, bounce, single lit LED:
//  - With dir=left at bit LED_W-1: dir flips to right and the LED moves right the same step.
//  - Mirror rule at bit0.
//  - Each end is lit for one step only. LED_W=8: 01,02,..,80,40,..,02,01,02..
//  Mode 11, fill/drain:
//  - diode <= {diode[LED_W-2:0], fill_bit}.
//  - When the new value is all ones, fill_bit <= 0. When the new value is all zeros, fill_bit <= 1.
//  - LED_W=8 sequence: 00,01,03,..,FF,FE,FC,..,00,01..
//  Reset asserted mid-pattern:
//  - The next edge forces all reset values, regardless of enable, div_load or mode.
//  - tick = 0 in the cycle after reset.
// TESTING
//  1. Reset, DIV_INIT=4, mode=00, enable=1, LED_W=8:
//     -> tick every 5 clocks; diode 01,02,04,..,80,01; tick high 1 cycle each step.
//  2. mode=10, div_value=0 loaded:
//     -> diode steps every clock: 01,02,..,80,40,..,01,02; no repeated end value.
//  3. Switch mode 00 -> 11 mid-run:
//     -> the next step shows 00, then 01,03,07,..,FF,FE,..,00.
//  4. enable=0 for 10 clocks mid-count:
//     -> diode and tick frozen; after enable=1 the step arrives after the remaining count, not a full period.
//  5. div_load pulse in the same cycle as cnt == div_reg (div_value=2):
//     -> no step, no tick that cycle; the next step arrives 3 clocks later.
//  6. reset_n=0 for 1 clock while in mode 01 with diode=10:
//     -> diode=01, tick=0 next cycle; stepping resumes in mode 00 with period DIV_INIT+1.

Source files
------------

// File: rtl/led_chaser_div_if.sv
// Control/status bundle for the LED chaser.
//   enable    : run (1) or freeze (0) the divider and pattern
//   div_load  : one-cycle pulse, captures div_value into the divisor register
//   div_value : new divisor; step period becomes div_value+1 clocks
//   mode      : 00 rotate-left, 01 rotate-right, 10 bounce, 11 fill/drain
//   diode     : registered LED pattern
//   tick      : registered one-cycle strobe marking each pattern step
// The master modport belongs to whoever drives the controls (board top or
// bench); the slave modport belongs to the chaser itself.
interface led_chaser_div_if #(
    parameter int LED_W = 8,
    parameter int DIV_W = 8
);
    logic             enable;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic [1:0]       mode;
    logic [LED_W-1:0] diode;
    logic             tick;

    modport master (
        output enable, div_load, div_value, mode,
        input  diode, tick
    );

    modport slave (
        input  enable, div_load, div_value, mode,
        output diode, tick
    );
endinterface

// File: rtl/led_chaser_div.sv
// LED pattern generator with a built-in programmable rate divider.
// The divider yields a clock-enable (step) rather than a derived clock, so
// everything runs on 'clock'.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : synchronous reset, active low
//   bus     : led_chaser_div_if.slave (enable, div_load, div_value, mode in;
//             diode, tick out)
module led_chaser_div #(
    parameter int LED_W    = 8,
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    led_chaser_div_if.slave   bus
);

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    logic [DIV_W-1:0] cnt_reg,   cnt_next;
    logic [DIV_W-1:0] div_reg,   div_next;
    logic [LED_W-1:0] diode_reg, diode_next;
    logic             tick_reg,  tick_next;
    dir_e             dir_reg,   dir_next;
    logic             fill_reg,  fill_next;
    mode_e            mode_reg,  mode_next;

    logic             step;
    mode_e            mode_in;
    logic [LED_W-1:0] fill_shift;

    assign mode_in    = mode_e'(bus.mode);
    assign fill_shift = {diode_reg[LED_W-2:0], fill_reg};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            div_reg   <= DIV_W'(DIV_INIT);
            diode_reg <= LED_W'(1);
            tick_reg  <= 1'b0;
            dir_reg   <= DIR_LEFT;
            fill_reg  <= 1'b1;
            mode_reg  <= MODE_ROL;
        end else begin
            cnt_reg   <= cnt_next;
            div_reg   <= div_next;
            diode_reg <= diode_next;
            tick_reg  <= tick_next;
            dir_reg   <= dir_next;
            fill_reg  <= fill_next;
            mode_reg  <= mode_next;
        end
    end

    always_comb begin
        cnt_next   = cnt_reg;
        div_next   = div_reg;
        diode_next = diode_reg;
        tick_next  = 1'b0;
        dir_next   = dir_reg;
        fill_next  = fill_reg;
        mode_next  = mode_reg;
        step       = 1'b0;

        // A divisor load restarts the count and suppresses any step that
        // would have fired this cycle, regardless of enable.
        if (bus.div_load) begin
            div_next = bus.div_value;
            cnt_next = '0;
        end else if (bus.enable) begin
            if (cnt_reg == div_reg) begin
                cnt_next = '0;
                step     = 1'b1;
            end else begin
                cnt_next = cnt_reg + DIV_W'(1);
            end
        end

        if (step) begin
            tick_next = 1'b1;
            if (mode_in != mode_reg) begin
                // Mode change: this step loads the new mode's seed instead
                // of advancing the old pattern.
                mode_next = mode_in;
                case (mode_in)
                    MODE_ROL:    diode_next = LED_W'(1);
                    MODE_ROR:    diode_next = {1'b1, {(LED_W-1){1'b0}}};
                    MODE_BOUNCE: begin
                        diode_next = LED_W'(1);
                        dir_next   = DIR_LEFT;
                    end
                    default: begin
                        diode_next = '0;
                        fill_next  = 1'b1;
                    end
                endcase
            end else begin
                case (mode_reg)
                    MODE_ROL: diode_next = {diode_reg[LED_W-2:0], diode_reg[LED_W-1]};
                    MODE_ROR: diode_next = {diode_reg[0], diode_reg[LED_W-1:1]};
                    MODE_BOUNCE: begin
                        // Turn around on the same step that reaches an end,
                        // so each end LED is lit for exactly one step.
                        if (dir_reg == DIR_LEFT) begin
                            if (diode_reg[LED_W-1]) begin
                                dir_next   = DIR_RIGHT;
                                diode_next = diode_reg >> 1;
                            end else begin
                                diode_next = diode_reg << 1;
                            end
                        end else begin
                            if (diode_reg[0]) begin
                                dir_next   = DIR_LEFT;
                                diode_next = diode_reg << 1;
                            end else begin
                                diode_next = diode_reg >> 1;
                            end
                        end
                    end
                    default: begin
                        diode_next = fill_shift;
                        if (&fill_shift) begin
                            fill_next = 1'b0;
                        end else if (~|fill_shift) begin
                            fill_next = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.diode = diode_reg;
    assign bus.tick  = tick_reg;

endmodule

// File: tb/tb_led_chaser_div.sv
// Scoreboard bench for led_chaser_div (LED_W=8, DIV_W=8, DIV_INIT=4).
// Stimulus pushes {cycle, diode} for every expected tick; the monitor pops
// and compares whenever the DUT raises tick, and flags missing or stray ticks.
module tb_led_chaser_div;

    localparam int LED_W    = 8;
    localparam int DIV_W    = 8;
    localparam int DIV_INIT = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    led_chaser_div_if #(.LED_W(LED_W), .DIV_W(DIV_W)) bus ();

    led_chaser_div #(
        .LED_W    (LED_W),
        .DIV_W    (DIV_W),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int         cyc;
        logic [7:0] diode;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic push(input int c, input logic [7:0] d);
        exp_t e;
        e.cyc   = c;
        e.diode = d;
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one line per observed step.
    always @(negedge clock) begin
        if (mon_en) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                mon_e = sb_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_tick: no tick at cycle %0d, required diode %0h", mon_e.cyc, mon_e.diode);
            end
            if (bus.tick === 1'b1) begin
                if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tick: tick at cycle %0d, diode %0h, none required", cyc, bus.diode);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("step cycle %0d diode %0h (required %0h)", cyc, bus.diode, mon_e.diode);
                    check("tick_diode", 32'(bus.diode), 32'(mon_e.diode));
                end
            end else if (bus.tick !== 1'b0) begin
                check("tick_known", 32'(bus.tick), 32'd0);
            end
        end
    end

    int c0, c1, c2, c3, c4;
    logic [7:0] rol_seq [8]     = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bounce_seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fill_seq [18]   = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};

    initial begin
        bus.enable    = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_value = '0;
        bus.mode      = 2'b00;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_diode", 32'(bus.diode), 32'h01);
        check("reset_tick",  32'(bus.tick),  32'h0);
        mon_en = 1'b1;

        // 1: default divider, rotate-left, period DIV_INIT+1 = 5
        c0 = cyc;
        reset_n    = 1'b1;
        bus.enable = 1'b1;
        for (int k = 0; k < 8; k++) push(c0 + 5 * (k + 1), rol_seq[k]);
        repeat (40) @(negedge clock);

        // 2: bounce, div 0 -> step every clock after the load cycle
        c1 = cyc;
        bus.mode      = 2'b10;
        bus.div_load  = 1'b1;
        bus.div_value = 8'd0;
        for (int k = 0; k < 16; k++) push(c1 + 2 + k, bounce_seq[k]);
        @(negedge clock);
        bus.div_load = 1'b0;
        repeat (16) @(negedge clock);

        // 3: rotate-left with div 3, then switch to fill/drain mid-run
        c2 = cyc;
        bus.mode      = 2'b00;
        bus.div_load  = 1'b1;
        bus.div_value = 8'd3;
        push(c2 + 5,  8'h01);
        push(c2 + 9,  8'h02);
        push(c2 + 13, 8'h04);
        @(negedge clock);
        bus.div_load = 1'b0;
        repeat (13) @(negedge clock);
        bus.mode = 2'b11;
        for (int k = 0; k < 18; k++) push(c2 + 17 + 4 * k, fill_seq[k]);
        repeat (71) @(negedge clock);

        // 4: freeze for 10 clocks with cnt = 2; only the remaining count follows
        c3 = cyc;
        repeat (2) @(negedge clock);
        bus.enable = 1'b0;
        repeat (10) @(negedge clock);
        check("frozen_diode", 32'(bus.diode), 32'h01);
        bus.enable = 1'b1;
        push(c3 + 14, 8'h03);
        repeat (5) @(negedge clock);

        // 5: load div 2 exactly when cnt == div_reg; the step is suppressed
        bus.div_load  = 1'b1;
        bus.div_value = 8'd2;
        push(c3 + 21, 8'h07);
        push(c3 + 24, 8'h0F);
        @(negedge clock);
        bus.div_load = 1'b0;
        repeat (6) @(negedge clock);

        // 6: rotate-right to diode 10, then reset with a competing div_load
        c4 = cyc;
        bus.mode = 2'b01;
        push(c4 + 3,  8'h80);
        push(c4 + 6,  8'h40);
        push(c4 + 9,  8'h20);
        push(c4 + 12, 8'h10);
        repeat (12) @(negedge clock);
        reset_n       = 1'b0;
        bus.mode      = 2'b00;
        bus.div_load  = 1'b1;
        bus.div_value = 8'd7;
        @(negedge clock);
        check("midrun_reset_diode", 32'(bus.diode), 32'h01);
        check("midrun_reset_tick",  32'(bus.tick),  32'h0);
        reset_n      = 1'b1;
        bus.div_load = 1'b0;
        push(c4 + 18, 8'h02);
        push(c4 + 23, 8'h04);
        repeat (12) @(negedge clock);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
